// File: rtl/bump_sequencer_pkg.sv
// Shared drive codes and sequencer state encoding for the bumper-avoidance robot.
// The motor driver and the controller use these same definitions.
package bump_sequencer_pkg;

   typedef enum logic [2:0] {
      DRV_STOP   = 3'd0,
      DRV_FWD    = 3'd1,
      DRV_REV    = 3'd2,
      DRV_SPIN_L = 3'd3,
      DRV_SPIN_R = 3'd4
   } drive_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FWD   = 3'd1,
      ST_BRAKE = 3'd2,
      ST_BACK  = 3'd3,
      ST_TURN  = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bump_debounce.sv
// Single-bit debouncer: the output follows the input only after the input has
// differed from it for STABLE_CYCLES consecutive clocks.
module bump_debounce #(
   parameter int   STABLE_CYCLES = 8,
   parameter logic RESET_VAL     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic deb
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

   logic [CNT_W-1:0] cnt;

   // Any return of raw to the current output restarts the stability window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         deb <= RESET_VAL;
         cnt <= '0;
      end else if (raw == deb) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
         deb <= raw;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bump_sequencer.sv
// Bump-and-turn sequencer: drives forward, and on a bumper hit stops, reverses,
// spins away from the obstacle and resumes forward motion.
module bump_sequencer #(
   parameter int CLK_HZ   = 12_000_000,
   parameter int DEB_MS   = 10,
   parameter int BRAKE_MS = 50,
   parameter int BACK_MS  = 300,
   parameter int TURN_MS  = 400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       halt,
   input  logic [5:0] bmp,
   output logic [2:0] drive,
   output logic       busy,
   output logic [7:0] bump_cnt
);
   import bump_sequencer_pkg::*;

   localparam int TICK_DIV = CLK_HZ / 1000;
   localparam int PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DEB_CYC  = TICK_DIV * DEB_MS;
   localparam int MAX_MS   = max3(BRAKE_MS, BACK_MS, TURN_MS);
   localparam int MS_W     = (MAX_MS > 1) ? $clog2(MAX_MS) : 1;

   logic [1:0]       start_sync, halt_sync;
   logic [5:0]       bmp_meta, bmp_sync, bmp_deb;
   logic             start_q, start_rise, halt_s;
   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic [MS_W-1:0]  ms_cnt;
   state_t           state, next_state;
   drive_t           drive_r, next_drive;
   logic             next_busy, turn_right, bump_any, left_only, accept;

   // NOTE: every flop uses <= so all registers update together from pre-edge values.
   // Bumpers are active-low, so their synchronizer stages idle at 1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_sync <= '0;
         halt_sync  <= '0;
         bmp_meta   <= '1;
         bmp_sync   <= '1;
         start_q    <= 1'b0;
      end else begin
         start_sync <= {start_sync[0], start};
         halt_sync  <= {halt_sync[0], halt};
         bmp_meta   <= bmp;
         bmp_sync   <= bmp_meta;
         start_q    <= start_sync[1];
      end
   end

   assign start_rise = start_sync[1] & ~start_q;
   assign halt_s     = halt_sync[1];

   for (genvar i = 0; i < 6; i++) begin : g_deb
      bump_debounce #(
         .STABLE_CYCLES(DEB_CYC),
         .RESET_VAL    (1'b1)
      ) u_deb (
         .clk(clk),
         .rst(rst),
         .raw(bmp_sync[i]),
         .deb(bmp_deb[i])
      );
   end

   assign bump_any  = ~&bmp_deb;
   assign left_only = (~&bmp_deb[5:3]) & (&bmp_deb[2:0]);
   assign tick      = (pre_cnt == PRE_W'(TICK_DIV - 1));

   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      next_state = state;
      next_drive = DRV_STOP;
      next_busy  = 1'b0;
      unique case (state)
         ST_IDLE:  if (start_rise) next_state = ST_FWD;
         ST_FWD:   if (bump_any) next_state = ST_BRAKE;
         ST_BRAKE: if (tick && ms_cnt == MS_W'(BRAKE_MS - 1)) next_state = ST_BACK;
         ST_BACK:  if (tick && ms_cnt == MS_W'(BACK_MS - 1)) next_state = ST_TURN;
         ST_TURN:  if (tick && ms_cnt == MS_W'(TURN_MS - 1)) next_state = ST_FWD;
         default:  next_state = ST_IDLE;
      endcase
      if (halt_s) next_state = ST_IDLE;

      // Outputs are decoded from the next state so they register alongside it.
      case (next_state)
         ST_FWD:   next_drive = DRV_FWD;
         ST_BRAKE: next_busy  = 1'b1;
         ST_BACK: begin
            next_drive = DRV_REV;
            next_busy  = 1'b1;
         end
         ST_TURN: begin
            next_drive = turn_right ? DRV_SPIN_R : DRV_SPIN_L;
            next_busy  = 1'b1;
         end
         default: next_drive = DRV_STOP;
      endcase
   end

   assign accept = (state == ST_FWD) && (next_state == ST_BRAKE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         drive_r    <= DRV_STOP;
         busy       <= 1'b0;
         turn_right <= 1'b0;
         bump_cnt   <= '0;
         pre_cnt    <= '0;
         ms_cnt     <= '0;
      end else begin
         state   <= next_state;
         drive_r <= next_drive;
         busy    <= next_busy;
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         if (next_state != state) ms_cnt <= '0;
         else if (tick)           ms_cnt <= ms_cnt + 1'b1;
         if (accept) begin
            turn_right <= left_only;
            if (bump_cnt != 8'hFF) bump_cnt <= bump_cnt + 1'b1;
         end
      end
   end

   assign drive = drive_r;

endmodule

// File: tb/tb_bump_sequencer.sv
// Self-checking bench for bump_sequencer with a scaled-down clock (4 cycles per ms).
// Expected drive segments are queued when a bump is applied and consumed as drive changes.
module tb_bump_sequencer;

   localparam int P = 4;

   logic       clk = 1'b0;
   logic       rst, start, halt;
   logic [5:0] bmp;
   logic [2:0] drive;
   logic       busy;
   logic [7:0] bump_cnt;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   typedef struct {
      logic [2:0] drv;
      int         min_c;
      int         max_c;
   } seg_t;

   seg_t exp_q[$];

   always #5 clk = ~clk;

   bump_sequencer #(
      .CLK_HZ  (4000),
      .DEB_MS  (2),
      .BRAKE_MS(1),
      .BACK_MS (3),
      .TURN_MS (2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .halt    (halt),
      .bmp     (bmp),
      .drive   (drive),
      .busy    (busy),
      .bump_cnt(bump_cnt)
   );

   task automatic push_seg(input logic [2:0] d, input int ms);
      seg_t s;
      s.drv   = d;
      s.min_c = (ms == 0) ? 0 : (ms - 1) * P + 1;
      s.max_c = ms * P;
      exp_q.push_back(s);
   endtask

   task automatic push_manoeuvre(input logic [2:0] turn_drv);
      push_seg(3'd0, 1);
      push_seg(3'd2, 3);
      push_seg(turn_drv, 2);
      push_seg(3'd1, 0);
   endtask

   task automatic expect_segments(input string name);
      seg_t       e, cur;
      bit         have_cur;
      logic [2:0] last;
      int         len;
      have_cur = 1'b0;
      last     = drive;
      while (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         len = 0;
         do begin
            @(negedge clk);
            len++;
         end while (drive === last && len < 40);
         if (drive === last) begin
            checks++;
            errors++;
            $display("FAIL %s: drive stuck at %0d, expected change to %0d", name, drive, e.drv);
            exp_q.delete();
            return;
         end
         if (have_cur && cur.max_c > 0) begin
            checks++;
            if (len < cur.min_c || len > cur.max_c) begin
               errors++;
               $display("FAIL %s: drive %0d lasted %0d cycles, expected %0d..%0d",
                        name, cur.drv, len, cur.min_c, cur.max_c);
            end
         end
         checks++;
         if (drive !== e.drv) begin
            errors++;
            $display("FAIL %s: drive got %0d expected %0d", name, drive, e.drv);
         end
         last     = drive;
         cur      = e;
         have_cur = 1'b1;
      end
   endtask

   task automatic wait_drive(input logic [2:0] d, input int budget, input string name,
                             output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (drive !== d && n < budget);
      if (drive !== d) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout, drive got %0d expected %0d", name, drive, d);
      end
   endtask

   task automatic press_until_brake(input logic [5:0] mask, input string name);
      int n;
      bmp = ~mask;
      wait_drive(3'd0, 40, name, n);
      bmp = 6'h3F;
   endtask

   task automatic check_cnt(input string name);
      checks++;
      if (bump_cnt !== 8'(exp_cnt)) begin
         errors++;
         $display("FAIL %s: bump_cnt got %0d expected %0d", name, bump_cnt, exp_cnt);
      end
   endtask

   task automatic test_reset;
      rst   = 1'b0;
      start = 1'b0;
      halt  = 1'b0;
      bmp   = 6'h3F;
      repeat (3) @(negedge clk);
      checks++;
      if (drive !== 3'd0) begin errors++; $display("FAIL reset_drive: got %0d expected 0", drive); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      check_cnt("reset_cnt");
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_start;
      int n;
      start = 1'b1;
      wait_drive(3'd1, 30, "start_fwd", n);
      checks++;
      if (n > 6) begin errors++; $display("FAIL start_latency: got %0d cycles expected <= 6", n); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_busy: got %b expected 0", busy); end
      for (int i = n; i < 20; i++) @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_bump_left;
      exp_cnt++;
      push_manoeuvre(3'd4);
      fork
         press_until_brake(6'b010000, "left_press");
         expect_segments("left_seq");
      join
      check_cnt("left_cnt");
      repeat (12) @(negedge clk);
      checks++;
      if (drive !== 3'd1) begin errors++; $display("FAIL left_settle: drive got %0d expected 1", drive); end
   endtask

   task automatic test_both_and_glitch;
      exp_cnt++;
      push_manoeuvre(3'd3);
      fork
         press_until_brake(6'b001010, "both_press");
         expect_segments("both_seq");
      join
      check_cnt("both_cnt");
      repeat (12) @(negedge clk);
      bmp[0] = 1'b0;
      repeat (P) @(negedge clk);
      bmp[0] = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (drive !== 3'd1) begin errors++; $display("FAIL glitch_drive: got %0d expected 1", drive); end
      check_cnt("glitch_cnt");
   endtask

   task automatic test_halt;
      int n;
      exp_cnt++;
      press_until_brake(6'b000001, "halt_press");
      wait_drive(3'd2, 20, "halt_back", n);
      halt = 1'b1;
      wait_drive(3'd0, 10, "halt_stop", n);
      checks++;
      if (n > 3) begin errors++; $display("FAIL halt_latency: got %0d cycles expected <= 3", n); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL halt_busy: got %b expected 0", busy); end
      repeat (20) @(negedge clk);
      start = 1'b1;
      repeat (6) @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (drive !== 3'd0) begin errors++; $display("FAIL halt_ignore_start: drive got %0d expected 0", drive); end
      halt = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      wait_drive(3'd1, 10, "halt_restart", n);
      checks++;
      if (n > 6) begin errors++; $display("FAIL restart_latency: got %0d cycles expected <= 6", n); end
      start = 1'b0;
      check_cnt("halt_cnt");
      repeat (5) @(negedge clk);
   endtask

   task automatic test_saturation;
      int         events, cycles, n;
      bit         spin_r_seen;
      logic [2:0] last;
      events      = 0;
      cycles      = 0;
      spin_r_seen = 1'b0;
      last        = drive;
      bmp[2]      = 1'b0;
      while (events < 300 && cycles < 12000) begin
         @(negedge clk);
         cycles++;
         if (drive === 3'd4) spin_r_seen = 1'b1;
         if (last === 3'd1 && drive === 3'd0) begin
            events++;
            if (exp_cnt < 255) exp_cnt++;
            if (events == 100) check_cnt("sat_mid_cnt");
         end
         last = drive;
      end
      checks++;
      if (events < 300) begin
         errors++;
         $display("FAIL sat_events: got %0d bump events expected 300", events);
      end
      check_cnt("sat_final_cnt");
      checks++;
      if (spin_r_seen) begin errors++; $display("FAIL sat_turn: saw drive 4 expected only 3 for right bumper"); end
      bmp = 6'h3F;
      repeat (60) @(negedge clk);
      wait_drive(3'd1, 60, "sat_resume", n);
   endtask

   task automatic test_reset_mid;
      int n;
      press_until_brake(6'b100000, "rst_press");
      wait_drive(3'd4, 40, "rst_turn", n);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      exp_cnt = 0;
      checks++;
      if (drive !== 3'd0) begin errors++; $display("FAIL rstmid_drive: got %0d expected 0", drive); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      check_cnt("rstmid_cnt");
      @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      checks++;
      if (drive !== 3'd0) begin errors++; $display("FAIL rstmid_idle: drive got %0d expected 0", drive); end
      start = 1'b1;
      wait_drive(3'd1, 10, "rstmid_restart", n);
      start = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_start();
      test_bump_left();
      test_both_and_glitch();
      test_halt();
      test_saturation();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bump_sequencer.md
BUMP_SEQUENCER -- requirements
Module: bump_sequencer

Interface
REQ-001 Parameter CLK_HZ, default 12_000_000, system clock frequency in Hz.
REQ-002 Parameter DEB_MS, default 10, bumper debounce stable time in ms.
REQ-003 Parameter BRAKE_MS, default 50, stop dwell after a bump in ms.
REQ-004 Parameter BACK_MS, default 300, reverse duration in ms.
REQ-005 Parameter TURN_MS, default 400, spin-away duration in ms.
REQ-006 clk  in  1  system clock; the only clock; all flops on rising edge.
REQ-007 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 start  in  1  level, asynchronous switch; a synchronized rising edge arms the robot.
REQ-009 halt  in  1  level, asynchronous; synchronized high forces IDLE.
REQ-010 bmp  in  6  bumper switches, active-low; bmp[2:0] = right side, bmp[5:3] = left side.
REQ-011 drive  out  3  motor command to motor_driver: 0 STOP, 1 FWD, 2 REV, 3 SPIN_L, 4 SPIN_R; 5-7 never driven.
REQ-012 busy  out  1  high while in BRAKE, BACK or TURN.
REQ-013 bump_cnt  out  8  count of accepted bump events.

Function
REQ-014 start, halt and each bmp bit SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Each synchronized bmp bit SHALL be debounced: the debounced value changes only after the raw value has been stable for DEB_MS ms; counter restarts on any change.
REQ-016 A 1 ms tick SHALL be generated by a prescaler counting 0..CLK_HZ/1000-1; the tick pulses one cycle at terminal count; the prescaler runs free from reset.
REQ-017 A single ms duration counter SHALL time BRAKE, BACK and TURN; it loads 0 on every state entry and increments on each tick; a state exits on the tick where count+1 equals its duration.
REQ-018 States: IDLE, FWD, BRAKE, BACK, TURN; drive = STOP in IDLE/BRAKE, FWD in FWD, REV in BACK, SPIN_L or SPIN_R in TURN.
REQ-019 IDLE -> FWD on a synchronized start rising edge with halt low.
REQ-020 FWD -> BRAKE in the cycle after any debounced bumper asserts; that cycle latches the side: left-only -> turn right, right-only -> turn left, both -> turn left.
REQ-021 BRAKE -> BACK -> TURN -> FWD on expiry of BRAKE_MS, BACK_MS and TURN_MS respectively.
REQ-022 Bumps during BRAKE/BACK/TURN SHALL be ignored (neither re-latched nor counted); a bumper still pressed on return to FWD SHALL trigger a new bump the next cycle.
REQ-023 bump_cnt SHALL increment by 1 on each FWD -> BRAKE transition and saturate at 255.
REQ-024 halt high SHALL force IDLE from any state in the next cycle and take priority over bumps and timer expiry; start edges are ignored while halt is high.
REQ-025 drive SHALL be registered, changing in the same cycle as the state register, so no glitch reaches motor_driver.

Reset
REQ-026 While rst = 0: state = IDLE, drive = STOP, busy = 0, bump_cnt = 0, turn side = left, prescaler, duration and debounce counters = 0, synchronizers = inactive (bmp = 1, start/halt = 0).
REQ-027 Reset asserted mid-manoeuvre SHALL return drive to STOP immediately (asynchronously); after release the block waits in IDLE for a fresh start edge.

Structure
REQ-028 Drive codes and the state enumeration SHALL live in a shared package, also used by motor_driver and controller.
REQ-029 Debounce SHALL be a sub-module bump_debounce (one instance per bit, parameterized by stable cycles); the ms timer stays inline.

Verification (CLK_HZ=4000, DEB_MS=2, BRAKE_MS=1, BACK_MS=3, TURN_MS=2)
REQ-030 Reset released, start pulsed high for 20 cycles -> drive = 1 within 4 cycles of the synchronized edge; busy = 0.
REQ-031 In FWD, bmp[4] = 0 held for 5 ms -> drive 0 for 1 ms, 2 for 3 ms, 4 for 2 ms, then 1; bump_cnt = 1.
REQ-032 bmp[1] and bmp[3] low together -> TURN uses drive = 3; a 1 ms glitch on bmp[0] -> no state change.
REQ-033 halt asserted during BACK -> drive = 0 and state IDLE within 3 cycles; a later start edge with halt low -> FWD.
REQ-034 bmp[2] held low indefinitely -> repeated bump cycles; bump_cnt saturates at 255 after 300 events.
REQ-035 rst = 0 pulsed during TURN -> drive = 0 in the same cycle; all outputs at reset values.
